// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, controller states and the arithmetic result bundle.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } mdu_res_t;

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage MDU bundle: operation request from the pipeline, HI/LO, busy and stall back to it.
interface mdu_ctrl_if;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        md_use_D;
  logic        busy;
  logic        stall_D;
  logic [31:0] HI_E;
  logic [31:0] LO_E;

  modport master (
    output start_E, op_E, A_E, B_E, md_use_D,
    input  busy, stall_D, HI_E, LO_E
  );

  modport slave (
    input  start_E, op_E, A_E, B_E, md_use_D,
    output busy, stall_D, HI_E, LO_E
  );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// mdu_arith: combinational (op, A, B) -> {hi, lo, div0}; the controller decides when to commit it.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    res
);

  logic signed [63:0] sprod_s;
  logic        [63:0] uprod_s;
  logic signed [32:0] a33_s;
  logic signed [32:0] b33_s;
  logic signed [32:0] squot_s;
  logic signed [32:0] srem_s;
  logic        [31:0] ub_s;
  logic        [31:0] uquot_s;
  logic        [31:0] urem_s;
  logic               div0_s;
  logic               unused_s;

  assign sprod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod_s = {32'd0, a} * {32'd0, b};

  // 33-bit signed divide keeps 0x80000000 / -1 representable; the result wraps to 0x80000000.
  assign div0_s  = (b == 32'd0);
  assign a33_s   = $signed({a[31], a});
  assign b33_s   = div0_s ? 33'sd1 : $signed({b[31], b});
  assign squot_s = a33_s / b33_s;
  assign srem_s  = a33_s % b33_s;
  assign ub_s    = div0_s ? 32'd1 : b;
  assign uquot_s = a / ub_s;
  assign urem_s  = a % ub_s;
  assign unused_s = ^{squot_s[32], srem_s[32]};

  // Result select by operation; non-arithmetic ops produce a zero bundle.
  always_comb begin
    res = '0;
    case (mdu_op_e'(op))
      MDU_MULT:  res = '{hi: sprod_s[63:32], lo: sprod_s[31:0], div0: 1'b0};
      MDU_MULTU: res = '{hi: uprod_s[63:32], lo: uprod_s[31:0], div0: 1'b0};
      MDU_DIV:   res = '{hi: srem_s[31:0],   lo: squot_s[31:0], div0: div0_s};
      MDU_DIVU:  res = '{hi: urem_s,         lo: uquot_s,       div0: div0_s};
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl_chk.sv
// Protocol checker for mdu_ctrl: a new MDU op must never reach E while one is in flight.
module mdu_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic start_E,
  input logic busy
);

  // The D-stage stall should have held any MDU op back while busy.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start_E && busy))
    else $error("mdu_ctrl_chk: start_E asserted while busy");

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO, with fixed-latency busy and D-stage stall.
// Optional MDU_FLUSH_EN adds a flush input that aborts an in-flight operation without writing HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
`ifdef MDU_FLUSH_EN
  input logic flush,
`endif
  mdu_ctrl_if.slave mdu
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      hi_r, hi_s;
  logic [31:0]      lo_r, lo_s;
  logic [31:0]      pend_hi_r, pend_hi_s;
  logic [31:0]      pend_lo_r, pend_lo_s;
  logic             pend_div0_r, pend_div0_s;
  mdu_res_t         res_s;

  mdu_arith u_arith (
    .op  (mdu.op_E),
    .a   (mdu.A_E),
    .b   (mdu.B_E),
    .res (res_s)
  );

  // Next-state, counter, pending and HI/LO update.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    hi_s        = hi_r;
    lo_s        = lo_r;
    pend_hi_s   = pend_hi_r;
    pend_lo_s   = pend_lo_r;
    pend_div0_s = pend_div0_r;
    case (state_r)
      IDLE: begin
        if (mdu.start_E) begin
          case (mdu_op_e'(mdu.op_E))
            MDU_MULT, MDU_MULTU: begin
              state_s     = RUN;
              cnt_s       = CNT_W'(MULT_CYCLES);
              pend_hi_s   = res_s.hi;
              pend_lo_s   = res_s.lo;
              pend_div0_s = 1'b0;
            end
            MDU_DIV, MDU_DIVU: begin
              state_s     = RUN;
              cnt_s       = CNT_W'(DIV_CYCLES);
              pend_hi_s   = res_s.hi;
              pend_lo_s   = res_s.lo;
              pend_div0_s = res_s.div0;
            end
            MDU_MTHI: hi_s = mdu.A_E;
            MDU_MTLO: lo_s = mdu.A_E;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          state_s = IDLE;
          cnt_s   = '0;
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          if (!pend_div0_r) begin
            hi_s = pend_hi_r;
            lo_s = pend_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
`ifdef MDU_FLUSH_EN
    if (flush) begin
      state_s = IDLE;
      cnt_s   = '0;
      hi_s    = hi_r;
      lo_s    = lo_r;
    end else begin
      state_s = state_s;
    end
`endif
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      pend_hi_r   <= 32'd0;
      pend_lo_r   <= 32'd0;
      pend_div0_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      hi_r        <= hi_s;
      lo_r        <= lo_s;
      pend_hi_r   <= pend_hi_s;
      pend_lo_r   <= pend_lo_s;
      pend_div0_r <= pend_div0_s;
    end
  end

  assign mdu.busy    = (state_r == RUN);
  assign mdu.stall_D = mdu.md_use_D & ((state_r == RUN) | mdu.start_E);
  assign mdu.HI_E    = hi_r;
  assign mdu.LO_E    = lo_r;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller in the E stage of the P5/P6 pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu with a fixed-latency busy counter.
- Generates the D-stage stall for any mult/div/mfhi/mflo/mthi/mtlo that would collide with an in-flight operation.
- HI/LO values leave via the E→M pipeline and become the mfhi/mflo source of the writeback result select.

Parameters:
MULT_CYCLES, 5, busy duration for mult/multu (must be ≥1)
DIV_CYCLES, 10, busy duration for div/divu (must be ≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_E  input  1  E-stage instruction is an MDU op; qualifies op_E
op_E  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 reserved
A_E  input  32  rs operand, forwarded
B_E  input  32  rt operand, forwarded
md_use_D  input  1  D-stage instruction is any MDU-class op, including mfhi/mflo
busy  output  1  multi-cycle operation in flight
stall_D  output  1  freeze PC/F/D, bubble into E
HI_E  output  32  current HI
LO_E  output  32  current LO

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset state: HI=0, LO=0, busy=0, counter=0, FSM=IDLE, pending registers=0.
  - Reset mid-operation aborts it: HI/LO go to 0 and no completion write follows.
- FSM states: IDLE, RUN.
  - IDLE→RUN on start_E with op 0–3: latch the computed result into pending_hi/pending_lo; load counter with MULT_CYCLES (op 0–1) or DIV_CYCLES (op 2–3).
  - RUN: counter decrements each cycle. When counter==1: HI←pending_hi, LO←pending_lo, counter→0, go to IDLE.
  - busy = (state==RUN).
- Timing: start_E at cycle t gives busy=1 in cycles t+1 … t+N. New HI/LO are visible in cycle t+N+1, the same cycle busy drops.
- mthi/mtlo (op 4/5) in IDLE: HI or LO ← A_E at the edge ending the cycle. Single cycle, busy stays 0.
- start_E while busy=1: ignored; no state change. This is illegal given stall_D and should be flagged by an assertion.
- Reserved op 6/7 with start_E: no effect.
- stall_D = md_use_D & (busy | start_E); combinational.
- Arithmetic:
  - mult: signed 32×32→64, HI=upper, LO=lower.
  - multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divisor 0: busy runs the full DIV_CYCLES, and HI/LO are left unchanged at completion.
- HI_E/LO_E are plain register outputs, never the pending values.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- Defined:
  - Adds input `flush` (1 bit) for exception/interrupt support.
  - flush=1 forces IDLE with counter=0; HI/LO are not written.
  - flush=1 also suppresses any start_E or mthi/mtlo in that cycle.
  - flush has lower priority than reset.
- Undefined: port absent; an operation always runs to completion once started.

Decomposition:
- Shared package/header holds the MDU op encodings (MDU_MULT … MDU_MTLO) and the IDLE/RUN state encodings.
- The E-stage decoder reuses the op encodings.
- One natural sub-module, `mdu_arith`: purely combinational; (op, A, B) → {pending_hi, pending_lo, div0 flag}.
- The FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- mult, A=0xFFFFFFFE (−2), B=3 at t → busy=1 in t+1..t+5; cycle t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, same operands → cycle t+6: HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (−7), B=2 → busy t+1..t+10; cycle t+11: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, B=0 after mthi A=0x1234, mtlo A=0x5678 → busy 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- md_use_D=1 held during a mult → stall_D=1 in cycles t..t+5, 0 at t+6. md_use_D=0 → stall_D=0 throughout.
- reset asserted at t+3 of a div → busy=0, HI=LO=0 in the next cycle; no later write. With MDU_FLUSH_EN: flush at t+3 → busy=0, HI/LO retain their prior values.
